matrix_pb_driver: RTL
=====================

# matrix_pb_driver

Host-side driver for the calculator's button-and-display interface, working in the opposite direction to the calculator itself. It accepts key codes over a valid/ready handshake and turns each one into a timed pushbutton press on `pb[9:0]`. It then waits for the two-digit seven-segment display `ss[13:0]` to settle, decodes it back to digit values, and returns them with the red/blue LED states. It sits on-chip next to the calculator, on the same clock, and serves as a scripted stimulus/readback engine for bring-up and self-test.

## Interface
- `HOLD_CYCLES`, default 1000: cycles each pushbutton is held high (minimum 1).
- `GAP_CYCLES`, default 1000: cycles all buttons are held low after a release (minimum 1).
- `SETTLE_CYCLES`, default 16: consecutive unchanged cycles of `{ss,red,blue}` required before capture (minimum 1).
- `TIMEOUT_CYCLES`, default 65535: maximum cycles spent in SETTLE before a forced capture.
- `clk`, input, 1: system clock.
- `n_rst`, input, 1: synchronous, active-low reset.
- `key_valid`, input, 1: key code offered.
- `key_code`, input, 4: button index; 0–9 are valid.
- `key_ready`, output, 1: driver idle and able to accept a key.
- `key_err`, output, 1: one-cycle pulse when a code of 10–15 is accepted.
- `pb`, output, 10: pushbutton drive, one-hot or zero.
- `ss`, input, 14: display segments; `ss[6:0]` is digit0 and `ss[13:7]` is digit1, each ordered {g,f,e,d,c,b,a} and active-high.
- `red`, `blue`, input, 1 each: calculator LEDs.
- `disp_valid`, output, 1: one-cycle pulse when a capture completes.
- `disp_d1`, `disp_d0`, output, 4 each: decoded digits.
- `disp_red`, `disp_blue`, output, 1 each: captured LED states.
- `disp_err`, output, 1: captured digit pattern was undecodable, or the capture was forced by timeout.

## Operation
**States:** IDLE, PRESS, RELEASE, SETTLE, CAPTURE.

- **IDLE**
  - `key_ready`=1.
  - Handshake completes when `key_valid && key_ready` are both high on a rising edge.
  - Code 0–9: latch the code, go to PRESS.
  - Code 10–15: pulse `key_err` on the next cycle and stay in IDLE. No button press and no capture.
- **PRESS:** `pb[code]`=1 and all other bits 0, for exactly HOLD_CYCLES cycles, then go to RELEASE.
- **RELEASE:** `pb`=0 for exactly GAP_CYCLES cycles, then go to SETTLE.
- **SETTLE**
  - Each cycle, compare `{ss,red,blue}` against its value registered on the previous cycle.
  - A change resets the stable counter to 0.
  - When the stable counter reaches SETTLE_CYCLES, go to CAPTURE.
  - When the timeout counter reaches TIMEOUT_CYCLES, go to CAPTURE with a forced flag set.
- **CAPTURE:** single cycle.
  - Register the decoded digits, `red`, and `blue`.
  - Set `disp_err` = forced flag OR either digit undecodable.
  - Pulse `disp_valid`.
  - Return to IDLE.
- **Digit decode**
  - Standard patterns for 0–9: 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Blank 7'h00 decodes to 4'hE with no error.
  - Any other pattern decodes to 4'hF and sets the error.
- **Capture registers:** `disp_*` data outputs hold their values until the next capture or reset.
- **Handshake while busy:** `key_ready`=0 in every state except IDLE, and `key_valid` is ignored there.
- **Input timing:** `ss`, `red` and `blue` come from same-clock logic, so no synchronisers are used.

## Timing
- **Reset values:**
  - `pb`=0, `key_ready`=1 (IDLE).
  - `key_err`=0, `disp_valid`=0.
  - `disp_d1`=`disp_d0`=4'hE, `disp_red`=`disp_blue`=0, `disp_err`=0.
  - All counters and the forced flag = 0.
- **Accept to press:** with the handshake on edge T, `pb` is high during cycles T+1 … T+HOLD.
- **Release:** `pb` is low during cycles T+HOLD+1 … T+HOLD+GAP.
- **Capture latency:** with an unchanging display, `disp_valid` is high in cycle T+HOLD+GAP+SETTLE+1.
- **Back-to-back keys:** `key_ready` rises the cycle after `disp_valid`.
- **Reset mid-operation:** `n_rst` low at any edge forces every output to its reset value on that edge, including dropping `pb` immediately.
- **Simultaneous events in SETTLE:** if stability and timeout complete on the same cycle, stability wins and the forced flag is not set.
- **Counter widths:** each counter is `$clog2(max parameter + 1)` bits and saturates, never wrapping.

## Structure
- **`matrix_pb_pkg`:** holds the state enum `pb_state_t`, the `SEG_*` pattern constants, and the `DIGIT_BLANK` (4'hE) and `DIGIT_BAD` (4'hF) codes.
- **`seg7_decode`:** one combinational sub-module. Input 7-bit pattern; outputs 4-bit digit and an error flag. Instantiated twice, once per digit.
- **Top level:** holds the FSM, the three counters (phase, stable, timeout), and the capture registers.

## Test plan
Benches use HOLD=4, GAP=3, SETTLE=2, TIMEOUT=10 unless noted.

1. **Basic key and readback:** key_code=3 on edge T, display model holds 7'h06/7'h5B (digit1=1, digit0=2) → `pb`=10'h008 in cycles T+1..T+4, `pb`=0 in T+5..T+7, `disp_valid` in T+10 with d1=1, d0=2, `disp_err`=0.
2. **Invalid code:** key_code=12 → `key_err` pulse at T+1, `pb` stays 0, no `disp_valid`, `key_ready`=1 at T+1.
3. **Unstable display:** display toggles every cycle → forced capture after 10 SETTLE cycles with `disp_err`=1. Toggling stops after 4 cycles → normal capture, `disp_err`=0.
4. **Bad and blank patterns:** ss={7'h00, 7'h49} → d1=E, d0=F, `disp_err`=1. LEDs red=1, blue=0 are captured unchanged.
5. **Reset mid-press:** `n_rst` low during PRESS → `pb`=0 at that edge, `key_ready`=1, `disp_*` at reset values. A new key afterwards completes normally.
6. **Back-to-back keys:** `key_valid` held high with codes 0 then 9 → second accept occurs the cycle after the first `disp_valid`, with no overlapping `pb` bits.

Source files
------------

// File: rtl/matrix_pb_pkg.sv
// Shared types and constants for the pushbutton driver and its segment decoder.
package matrix_pb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_RELEASE,
    ST_SETTLE,
    ST_CAPTURE
  } pb_state_t;

  // Seven-segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_BLANK = 4'hE;
  localparam logic [3:0] DIGIT_BAD   = 4'hF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matrix_pb_driver_seg7_decode.sv
// Combinational seven-segment to digit decoder; blank is legal, anything
// outside the ten digit patterns is flagged.
module seg7_decode
  import matrix_pb_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       err
);

  // Pattern lookup with blank and undecodable fallbacks
  always_comb begin
    digit = DIGIT_BAD;
    err   = 1'b0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = DIGIT_BLANK;
      default: begin
        digit = DIGIT_BAD;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/matrix_pb_driver.sv
// Scripted pushbutton driver: presses one button per accepted key code, waits
// for the two-digit display to settle, then returns the decoded readback.
module matrix_pb_driver
  import matrix_pb_pkg::*;
#(
  parameter int HOLD_CYCLES    = 1000,
  parameter int GAP_CYCLES     = 1000,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic        key_err,
  output logic [9:0]  pb,
  input  logic [13:0] ss,
  input  logic        red,
  input  logic        blue,
  output logic        disp_valid,
  output logic [3:0]  disp_d1,
  output logic [3:0]  disp_d0,
  output logic        disp_red,
  output logic        disp_blue,
  output logic        disp_err
);

  localparam int PW = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // The phase counter counts 0..N-1 and the phase ends on its last value
  localparam logic [PW-1:0] HOLD_LAST    = PW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST     = PW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_FULL   = PW'(max2(HOLD_CYCLES, GAP_CYCLES));
  localparam logic [SW-1:0] SETTLE_FULL  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_FULL = TW'(TIMEOUT_CYCLES);

  pb_state_t     state_reg, state_next;
  logic [PW-1:0] phase_reg, phase_next, phase_inc;
  logic [SW-1:0] stable_reg, stable_next, stable_inc;
  logic [TW-1:0] timeout_reg, timeout_next, timeout_inc;
  logic [3:0]    code_reg;
  logic [15:0]   obs, obs_prev_reg;
  logic          key_err_reg;
  logic          disp_valid_reg;
  logic [3:0]    disp_d1_reg, disp_d0_reg;
  logic          disp_red_reg, disp_blue_reg, disp_err_reg;
  logic          accept, accept_ok, accept_bad;
  logic          capture_go, capture_forced;
  logic [3:0]    digit_dec [2];
  logic          digit_bad [2];

  // One decoder per display digit: index 0 is ss[6:0], index 1 is ss[13:7]
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      seg7_decode u_dec (
        .seg   (ss[gi*7 +: 7]),
        .digit (digit_dec[gi]),
        .err   (digit_bad[gi])
      );
    end
  endgenerate

  // Button drive comes straight from state so a reset drops it on the same edge
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_pb
      assign pb[gi] = (state_reg == ST_PRESS) && (code_reg == 4'(gi));
    end
  endgenerate

  assign obs        = {ss, red, blue};
  assign accept     = (state_reg == ST_IDLE) && key_valid;
  assign accept_ok  = accept && (key_code <= 4'd9);
  assign accept_bad = accept && (key_code > 4'd9);

  // Saturating increments so no counter can wrap
  assign phase_inc   = (phase_reg == PHASE_FULL) ? phase_reg : phase_reg + PW'(1);
  assign stable_inc  = (stable_reg == SETTLE_FULL) ? stable_reg : stable_reg + SW'(1);
  assign timeout_inc = (timeout_reg == TIMEOUT_FULL) ? timeout_reg : timeout_reg + TW'(1);

  // Next-state, counter and capture-strobe logic
  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    stable_next    = stable_reg;
    timeout_next   = timeout_reg;
    capture_go     = 1'b0;
    capture_forced = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        phase_next   = '0;
        stable_next  = '0;
        timeout_next = '0;
        if (accept_ok) state_next = ST_PRESS;
      end
      ST_PRESS: begin
        if (phase_reg == HOLD_LAST) begin
          state_next = ST_RELEASE;
          phase_next = '0;
        end else begin
          phase_next = phase_inc;
        end
      end
      ST_RELEASE: begin
        if (phase_reg == GAP_LAST) begin
          state_next   = ST_SETTLE;
          phase_next   = '0;
          stable_next  = '0;
          timeout_next = '0;
        end else begin
          phase_next = phase_inc;
        end
      end
      ST_SETTLE: begin
        stable_next  = (obs == obs_prev_reg) ? stable_inc : '0;
        timeout_next = timeout_inc;
        // Stability is checked first so it wins a same-cycle tie with timeout
        if (stable_next == SETTLE_FULL) begin
          capture_go = 1'b1;
        end else if (timeout_next == TIMEOUT_FULL) begin
          capture_go     = 1'b1;
          capture_forced = 1'b1;
        end
        if (capture_go) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_next   = ST_IDLE;
        stable_next  = '0;
        timeout_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counters, key latch and capture registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= '0;
      stable_reg     <= '0;
      timeout_reg    <= '0;
      code_reg       <= '0;
      obs_prev_reg   <= '0;
      key_err_reg    <= 1'b0;
      disp_valid_reg <= 1'b0;
      disp_d1_reg    <= DIGIT_BLANK;
      disp_d0_reg    <= DIGIT_BLANK;
      disp_red_reg   <= 1'b0;
      disp_blue_reg  <= 1'b0;
      disp_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      stable_reg     <= stable_next;
      timeout_reg    <= timeout_next;
      obs_prev_reg   <= obs;
      key_err_reg    <= accept_bad;
      disp_valid_reg <= capture_go;
      if (accept_ok) code_reg <= key_code;
      // Capture on the edge leaving SETTLE so data and valid appear together
      if (capture_go) begin
        disp_d1_reg   <= digit_dec[1];
        disp_d0_reg   <= digit_dec[0];
        disp_red_reg  <= red;
        disp_blue_reg <= blue;
        disp_err_reg  <= capture_forced | digit_bad[1] | digit_bad[0];
      end
    end
  end

  assign key_ready  = (state_reg == ST_IDLE);
  assign key_err    = key_err_reg;
  assign disp_valid = disp_valid_reg;
  assign disp_d1    = disp_d1_reg;
  assign disp_d0    = disp_d0_reg;
  assign disp_red   = disp_red_reg;
  assign disp_blue  = disp_blue_reg;
  assign disp_err   = disp_err_reg;

endmodule
